// File: rtl/zx_clk_pkg.sv
// Shared clock-scheduling definitions for the Spectrum core: speed codes,
// scheduler FSM states and the per-speed CPU edge slot decode.
package zx_clk_pkg;

    localparam int unsigned PH_W  = 3;
    localparam int unsigned SPD_W = 2;

    typedef logic [SPD_W-1:0] speed_t;

    localparam speed_t SPD_3M5 = 2'd0;
    localparam speed_t SPD_7M0 = 2'd1;
    localparam speed_t SPD_14M = 2'd2;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } sched_state_t;

    // Rising-edge slots within the 8-cycle frame
    function automatic logic is_pe_slot(input speed_t s, input logic [PH_W-1:0] ph);
        case (s)
            SPD_3M5: return ph == 3'd0;
            SPD_7M0: return ph[1:0] == 2'b00;
            default: return !ph[0];
        endcase
    endfunction

    // Falling-edge slots, each half a CPU period after the rising slot
    function automatic logic is_ne_slot(input speed_t s, input logic [PH_W-1:0] ph);
        case (s)
            SPD_3M5: return ph == 3'd4;
            SPD_7M0: return ph[1:0] == 2'b10;
            default: return ph[0];
        endcase
    endfunction

endpackage

// File: rtl/cpu_ce_sched.sv
// Z80 clock-enable scheduler: 8-cycle frames on the 28 MHz clock, pe/ne
// enables at 3.5/7/14 MHz, ULA contention stretch, frame-aligned speed switch.
module cpu_ce_sched
    import zx_clk_pkg::*;
(
    input  logic         clock,
    input  logic         power,
    input  logic [1:0]   speed_req,
    input  logic         contend,
    output logic         pe_cpu,
    output logic         ne_cpu,
    output logic [1:0]   speed,
    output logic         busy,
    output logic         stall
);

    sched_state_t    state, state_nxt;
    logic [PH_W-1:0] ph, ph_nxt;
    logic            lvl, lvl_nxt;
    speed_t          target, speed_nxt;
    logic            pe_slot, ne_slot, contended;
    logic            pe_nxt, ne_nxt, stall_nxt;

    always_ff @(posedge clock or negedge power) begin
        if (!power) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Speed FSM: hold a request until the 7->0 wrap, latest request wins
    always_comb begin
        state_nxt = state;
        speed_nxt = speed_t'(speed);
        target    = (speed_req == 2'd3) ? SPD_14M : speed_t'(speed_req);
        ph_nxt    = ph + PH_W'(1);
        case (state)
            ST_RUN: begin
                if (target != speed_t'(speed)) begin
                    state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                if (target == speed_t'(speed)) begin
                    state_nxt = ST_RUN;
                end else if (ph_nxt == '0) begin
                    state_nxt = ST_RUN;
                    speed_nxt = target;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Slot decode for the cycle being entered; contention only at steady base speed
    always_comb begin
        pe_slot   = is_pe_slot(speed_nxt, ph_nxt);
        ne_slot   = is_ne_slot(speed_nxt, ph_nxt);
        contended = contend && (speed_t'(speed) == SPD_3M5) && (speed_nxt == SPD_3M5);
        stall_nxt = pe_slot && contended;
        pe_nxt    = pe_slot && !lvl && !contended;
        ne_nxt    = ne_slot && lvl;
        lvl_nxt   = lvl;
        if (pe_nxt) begin
            lvl_nxt = 1'b1;
        end else if (ne_nxt) begin
            lvl_nxt = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge power) begin
        if (!power) begin
            ph     <= 3'd7;
            lvl    <= 1'b0;
            speed  <= 2'(SPD_3M5);
            pe_cpu <= 1'b0;
            ne_cpu <= 1'b0;
            busy   <= 1'b0;
            stall  <= 1'b0;
        end else begin
            ph     <= ph_nxt;
            lvl    <= lvl_nxt;
            speed  <= 2'(speed_nxt);
            pe_cpu <= pe_nxt;
            ne_cpu <= ne_nxt;
            busy   <= (state_nxt == ST_PEND);
            stall  <= stall_nxt;
        end
    end

endmodule

// File: tb/tb_cpu_ce_sched.sv
// Bench for cpu_ce_sched: directed scenarios plus random requests/contention,
// every cycle compared against a frame-position reference model.
module tb_cpu_ce_sched;

    logic       clock;
    logic       power;
    logic [1:0] speed_req;
    logic       contend;
    logic       pe_cpu, ne_cpu, busy, stall;
    logic [1:0] speed;

    int checks = 0;
    int errors = 0;

    // Reference model: position in frame, CPU period derived from speed
    int m_pos;
    int m_spd;
    bit m_pend;
    bit m_lvl;
    bit m_pe, m_ne, m_stall;
    int ncyc;

    cpu_ce_sched dut (
        .clock     (clock),
        .power     (power),
        .speed_req (speed_req),
        .contend   (contend),
        .pe_cpu    (pe_cpu),
        .ne_cpu    (ne_cpu),
        .speed     (speed),
        .busy      (busy),
        .stall     (stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 7; m_spd = 0; m_pend = 0; m_lvl = 0;
        m_pe = 0; m_ne = 0; m_stall = 0; ncyc = 0;
    endtask

    task automatic model_step(input int req, input bit c);
        int tgt, npos, nspd, per;
        bit pe_s, ne_s, sup;
        tgt  = (req == 3) ? 2 : req;
        npos = (m_pos + 1) % 8;
        nspd = m_spd;
        if (tgt == m_spd) m_pend = 0;
        else if (m_pend && npos == 0) begin nspd = tgt; m_pend = 0; end
        else m_pend = 1;
        per   = 8 >> nspd;
        pe_s  = (npos % per) == 0;
        ne_s  = (npos % per) == per / 2;
        sup   = c && m_spd == 0 && nspd == 0 && pe_s;
        m_pe    = pe_s && !m_lvl && !sup;
        m_ne    = ne_s && m_lvl;
        m_stall = sup;
        if (m_pe) m_lvl = 1;
        else if (m_ne) m_lvl = 0;
        m_spd = nspd;
        m_pos = npos;
        ncyc++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pe"},    {1'b0, pe_cpu}, {1'b0, m_pe});
        chk({tag, ".ne"},    {1'b0, ne_cpu}, {1'b0, m_ne});
        chk({tag, ".speed"}, speed, 2'(m_spd));
        chk({tag, ".busy"},  {1'b0, busy},   {1'b0, m_pend});
        chk({tag, ".stall"}, {1'b0, stall},  {1'b0, m_stall});
    endtask

    // Inputs are driven 1 time unit after an edge; outputs sampled 1 unit after the next
    task automatic cycle(input int req, input bit c, input string tag);
        speed_req = 2'(req);
        contend   = c;
        model_step(req, c);
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic run_to_pos(input int req, input int pos, input string tag);
        for (int i = 0; i < 8 && m_pos != pos; i++) cycle(req, 1'b0, tag);
    endtask

    initial begin
        int req;
        bit c;
        power = 1'b0; speed_req = 2'd0; contend = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_all("reset");

        // Base speed: pe at cycles 1, 9, 17 and ne at 5, 13
        power = 1'b1;
        for (int i = 0; i < 24; i++) begin
            cycle(0, 1'b0, "base");
            chk("base_pe_cyc", {1'b0, pe_cpu}, {1'b0, (ncyc % 8) == 1});
            chk("base_ne_cyc", {1'b0, ne_cpu}, {1'b0, (ncyc % 8) == 5});
        end

        // Switch 0->2 requested during ph=3
        run_to_pos(0, 3, "pre_sw");
        cycle(2, 1'b0, "sw_req");
        for (int i = 0; i < 4; i++) begin
            cycle(2, 1'b0, "sw_pend");
            chk("sw_busy_hi", {1'b0, busy}, {1'b0, m_pos != 0});
        end
        chk("sw_speed2", speed, 2'd2);
        for (int i = 0; i < 12; i++) cycle(2, 1'b0, "fast");

        // Back to base speed, then contention held for 20 cycles from ph=6
        for (int i = 0; i < 10; i++) cycle(0, 1'b0, "back0");
        run_to_pos(0, 5, "pre_ct");
        for (int i = 0; i < 20; i++) cycle(0, 1'b1, "contend");
        for (int i = 0; i < 16; i++) cycle(0, 1'b0, "post_ct");

        // Contention is ignored at 7 MHz
        for (int i = 0; i < 24; i++) begin
            cycle(1, 1'b1, "ct7");
            if (m_spd == 1) chk("ct7_stall", {1'b0, stall}, 2'd0);
        end
        for (int i = 0; i < 12; i++) cycle(0, 1'b0, "back0b");

        // Request toggled 0->1->0 within one frame leaves speed at 0
        run_to_pos(0, 1, "pre_tg");
        cycle(1, 1'b0, "tg1");
        cycle(0, 1'b0, "tg0");
        chk("tg_busy", {1'b0, busy}, 2'd0);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1'b0, "tg_after");
            chk("tg_speed", speed, 2'd0);
        end

        // Random requests and contention
        req = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) req = int'($urandom_range(0, 3));
            c = ($urandom_range(0, 2) == 0);
            cycle(req, c, "rand");
        end

        // Power drop at ph=5 during 14 MHz, then restart at base speed
        for (int i = 0; i < 20; i++) cycle(2, 1'b0, "to14");
        run_to_pos(2, 5, "pre_pd");
        power = 1'b0;
        #1;
        model_reset();
        check_all("pwr_drop");
        repeat (2) @(posedge clock);
        #1;
        check_all("pwr_low");
        power = 1'b1;
        cycle(2, 1'b0, "pwr_first");
        chk("pwr_first_pe", {1'b0, pe_cpu}, 2'd1);
        chk("pwr_speed0", speed, 2'd0);
        for (int i = 0; i < 16; i++) cycle(2, 1'b0, "pwr_run");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
